store_buffer: RTL and testbench

Posted-write buffer on the data side of the memory system, downstream of the data cache's store path. Queues word-granular stores (address, data, byte strobes) and drains them in order as single-beat AXI write transactions on the AW/W/B channels. The pipeline does not wait for the write response. Provides a read-after-write hazard check, so a load to a pending address can be held until the buffer drains that entry.

---
 rtl/store_buffer.sv | 181 ++++++++++++++++++
 tb/tb_store_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO of word stores drained as single-beat
// AXI writes, with a combinational read-after-write hazard check on pending entries.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [31:0] push_addr,
   input  logic [31:0] push_data,
   input  logic [3:0]  push_strb,
   output logic        full,
   output logic        empty,
   input  logic [31:0] rd_addr,
   output logic        rd_hit,
   output logic        err,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   // state | meaning
   // IDLE  | no transaction; launch AW/W for the head entry when count != 0
   // SEND  | AW and/or W still waiting for their handshakes
   // RESP  | both beats accepted, waiting for B; pop on bvalid
   typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

   localparam int            PW      = $clog2(DEPTH);
   localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

   logic [31:0]   mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [3:0]    mem_strb [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count, count_nxt;
   logic          push_ok, pop;

   state_t        state, state_nxt;
   logic          awvalid_nxt, wvalid_nxt;
   logic          aw_done, aw_done_nxt, w_done, w_done_nxt;
   logic          err_nxt;
   logic [31:0]   awaddr_nxt, wdata_nxt;
   logic [3:0]    wstrb_nxt;
   logic [PW-1:0] hit_ofs;
   logic          unused_rd_lsb;

   assign push_ok = push && !full;
   assign pop     = (state == RESP) && bvalid;

   assign awlen   = 4'b0000;
   assign awsize  = 3'b010;
   assign wlast   = wvalid;
   assign bready  = (state == RESP);

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr[i] <= '0;
            mem_data[i] <= '0;
            mem_strb[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
            mem_strb[wr_ptr] <= push_strb;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == DEPTH_C);
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         err     <= 1'b0;
         awaddr  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
      end else begin
         state   <= state_nxt;
         awvalid <= awvalid_nxt;
         wvalid  <= wvalid_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
         err     <= err_nxt;
         awaddr  <= awaddr_nxt;
         wdata   <= wdata_nxt;
         wstrb   <= wstrb_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      awvalid_nxt = awvalid;
      wvalid_nxt  = wvalid;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      err_nxt     = err;
      awaddr_nxt  = awaddr;
      wdata_nxt   = wdata;
      wstrb_nxt   = wstrb;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               state_nxt   = SEND;
               awvalid_nxt = 1'b1;
               wvalid_nxt  = 1'b1;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
               awaddr_nxt  = mem_addr[rd_ptr];
               wdata_nxt   = mem_data[rd_ptr];
               wstrb_nxt   = mem_strb[rd_ptr];
            end
         end
         SEND: begin
            if (awvalid && awready) begin
               awvalid_nxt = 1'b0;
               aw_done_nxt = 1'b1;
            end
            if (wvalid && wready) begin
               wvalid_nxt = 1'b0;
               w_done_nxt = 1'b1;
            end
            if (aw_done_nxt && w_done_nxt) state_nxt = RESP;
         end
         RESP: begin
            if (bvalid) begin
               state_nxt = IDLE;
               if (bresp != 2'b00) err_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An entry is valid when its distance from rd_ptr is below count; the head stays valid until popped.
   always_comb begin
      rd_hit  = 1'b0;
      hit_ofs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_ofs = PW'(i) - rd_ptr;
         if (({1'b0, hit_ofs} < count) && (mem_addr[i][31:2] == rd_addr[31:2]))
            rd_hit = 1'b1;
      end
   end

   assign unused_rd_lsb = ^rd_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a scoreboard of expected AW/W beats is filled at push
// time and drained by a bus monitor; a configurable slave drives the ready/response side.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        push = 1'b0;
   logic [31:0] push_addr = '0;
   logic [31:0] push_data = '0;
   logic [3:0]  push_strb = '0;
   logic        full, empty, rd_hit, err;
   logic [31:0] rd_addr = '0;
   logic [31:0] awaddr, wdata;
   logic [3:0]  awlen, wstrb;
   logic [2:0]  awsize;
   logic        awvalid, wvalid, wlast, bready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [1:0]  bresp = 2'b00;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_aw [$];
   logic [31:0] exp_wd [$];
   logic [3:0]  exp_ws [$];
   int aw_hs = 0;

   int aw_lat = 0, w_lat = 0, b_lat = 0;
   int aw_age = 0, w_age = 0, b_age = 0;
   int b_num = 0, bad_idx = -1;
   bit aw_en = 1'b1, w_en = 1'b1;

   store_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .push(push), .push_addr(push_addr), .push_data(push_data), .push_strb(push_strb),
      .full(full), .empty(empty), .rd_addr(rd_addr), .rd_hit(rd_hit), .err(err),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Slave: ready/valid asserted once the request has been waiting more than *_lat cycles.
   always @(posedge clk) begin
      if (bvalid && bready) b_num++;
      #1;
      aw_age  = awvalid ? aw_age + 1 : 0;
      w_age   = wvalid  ? w_age + 1  : 0;
      b_age   = bready  ? b_age + 1  : 0;
      awready = aw_en && awvalid && (aw_age > aw_lat);
      wready  = w_en && wvalid && (w_age > w_lat);
      bvalid  = bready && (b_age > b_lat);
      bresp   = (b_num == bad_idx) ? 2'b10 : 2'b00;
   end

   // Monitor: every cycle a beat is valid it must match the scoreboard head.
   always @(negedge clk) begin
      if (reset) begin
         if (awvalid) begin
            if (exp_aw.size() == 0) check("aw_unexpected", 32'd1, 32'd0);
            else begin
               check("awaddr", awaddr, exp_aw[0]);
               check("awlen_awsize", {25'd0, awsize, awlen}, {25'd0, 3'b010, 4'b0000});
               if (awready) begin
                  void'(exp_aw.pop_front());
                  aw_hs++;
               end
            end
         end
         if (wvalid) begin
            if (exp_wd.size() == 0) check("w_unexpected", 32'd1, 32'd0);
            else begin
               check("wdata", wdata, exp_wd[0]);
               check("wstrb_wlast", {27'd0, wlast, wstrb}, {27'd0, 1'b1, exp_ws[0]});
               if (wready) begin
                  void'(exp_wd.pop_front());
                  void'(exp_ws.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_aw.push_back(a);
      exp_wd.push_back(d);
      exp_ws.push_back(s);
   endtask

   task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      push_addr = a; push_data = d; push_strb = s; push = 1'b1;
      expect_beat(a, d, s);
      tick();
      push = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (!(empty && !awvalid && !wvalid && !bready) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check({"timeout_", tag}, 32'd0, 32'd1);
   endtask

   initial begin
      int hs0, b0;

      // Reset values
      #12;
      check("rst_full_empty", {30'd0, full, empty}, 32'd1);
      check("rst_valids", {28'd0, awvalid, wvalid, bready, err}, 32'd0);
      check("rst_awaddr", awaddr, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_wstrb_rdhit", {27'd0, rd_hit, wstrb}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Single store, zero-wait slave; cycle-exact timing
      push_one(32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
      check("t1_e0_empty_awvalid", {30'd0, empty, awvalid}, 32'd0);
      tick();
      check("t1_e1_valids", {29'd0, awvalid, wvalid, bready}, 32'b110);
      tick();
      check("t1_e2_resp", {29'd0, awvalid, wvalid, bready}, 32'b001);
      tick();
      check("t1_e3_empty_err", {29'd0, empty, bready, err}, 32'b100);

      // Fill to capacity with AW stalled; 5th push dropped
      aw_en = 1'b0;
      hs0 = aw_hs;
      for (int i = 0; i < 5; i++) begin
         push_addr = 32'hA000_0000 + 32'(i * 4);
         push_data = 32'h1111_0000 + 32'(i);
         push_strb = 4'(i + 1);
         push = 1'b1;
         if (i < 4) expect_beat(push_addr, push_data, push_strb);
         tick();
         check($sformatf("t2_full_after_push%0d", i + 1), {31'd0, full}, (i >= 3) ? 32'd1 : 32'd0);
      end
      push = 1'b0;
      aw_en = 1'b1;
      wait_idle("fill", 100);
      check("t2_drained", aw_hs - hs0, 32'd4);
      check("t2_queue_empty", exp_aw.size(), 32'd0);

      // Split handshake: W immediately, AW after 3 extra cycles
      aw_lat = 3;
      push_one(32'h3000_0010, 32'hCAFE_F00D, 4'b0110);
      tick();
      check("t3_e1_valids", {29'd0, awvalid, wvalid, bready}, 32'b110);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check($sformatf("t3_e%0d_aw_only", i), {29'd0, awvalid, wvalid, bready}, 32'b100);
      end
      tick();
      check("t3_e5_resp", {29'd0, awvalid, wvalid, bready}, 32'b001);
      wait_idle("split", 50);
      aw_lat = 0;

      // Hazard check
      b_lat = 3;
      rd_addr = 32'h2000_000B;
      push_addr = 32'h2000_0008; push_data = 32'h5555_AAAA; push_strb = 4'hF; push = 1'b1;
      #1;
      check("t4_same_cycle_push", {31'd0, rd_hit}, 32'd0);
      expect_beat(push_addr, push_data, push_strb);
      tick();
      push = 1'b0;
      #1;
      check("t4_hit_0B", {31'd0, rd_hit}, 32'd1);
      rd_addr = 32'h2000_000C;
      #1;
      check("t4_miss_0C", {31'd0, rd_hit}, 32'd0);
      rd_addr = 32'h2000_000B;
      begin
         int n = 0;
         while (!bready && n < 20) begin tick(); n++; end
         if (n >= 20) check("timeout_hazard_resp", 32'd0, 32'd1);
      end
      check("t4_hit_in_resp", {30'd0, bready, rd_hit}, 32'b11);
      wait_idle("hazard", 50);
      check("t4_clear_after_pop", {31'd0, rd_hit}, 32'd0);
      b_lat = 0;

      // Error response on the first of two stores
      bad_idx = b_num;
      hs0 = aw_hs;
      b0 = b_num;
      push_one(32'h4000_0000, 32'h0000_0001, 4'h1);
      push_one(32'h4000_0004, 32'h0000_0002, 4'h2);
      wait_idle("error", 100);
      bad_idx = -1;
      check("t5_err_set", {31'd0, err}, 32'd1);
      check("t5_both_drained", {16'(aw_hs - hs0), 16'(b_num - b0)}, {16'd2, 16'd2});
      repeat (3) tick();
      check("t5_err_sticky", {31'd0, err}, 32'd1);

      // Reset mid-transaction with 3 entries queued
      aw_en = 1'b0;
      w_en  = 1'b0;
      push_one(32'h6000_0000, 32'h6666_0000, 4'hF);
      push_one(32'h6000_0004, 32'h6666_0001, 4'hF);
      push_one(32'h6000_0008, 32'h6666_0002, 4'hF);
      check("t6_in_send", {30'd0, awvalid, wvalid}, 32'b11);
      #1;
      reset = 1'b0;
      #1;
      check("t6_async_valids", {28'd0, awvalid, wvalid, bready, err}, 32'd0);
      check("t6_async_flags", {30'd0, full, empty}, 32'd1);
      exp_aw.delete();
      exp_wd.delete();
      exp_ws.delete();
      tick();
      tick();
      reset = 1'b1;
      aw_en = 1'b1;
      w_en  = 1'b1;
      hs0 = aw_hs;
      repeat (8) tick();
      check("t6_no_activity", {14'd0, 16'(aw_hs - hs0), awvalid, wvalid}, 32'd0);
      check("t6_still_empty", {31'd0, empty}, 32'd1);
      push_one(32'h7000_0000, 32'h7777_7777, 4'hC);
      wait_idle("post_reset", 50);
      check("t6_new_store_drained", {16'(aw_hs - hs0), 16'(exp_aw.size())}, {16'd1, 16'd0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
